clk_freq_meter: RTL



---
 rtl/clk_freq_meter_if.sv | 17 +
 rtl/clk_freq_meter.sv | 114 +++++++++++
 2 files changed

// File: rtl/clk_freq_meter_if.sv
// Control/result bundle for clk_freq_meter: measurement requests in, published count out.
interface clk_freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic [CNT_W-1:0] freq_count;
  logic             count_valid;
  logic             overflow;
  logic             busy;

  modport master (output start, continuous, abort,
                  input  freq_count, count_valid, overflow, busy);
  modport slave  (input  start, continuous, abort,
                  output freq_count, count_valid, overflow, busy);
endinterface

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts sig_in rises over GATE_CYCLES sys_clk cycles, one-shot or free-running.
// Optional CLK_FREQ_METER_DEGLITCH_EN adds a third sync stage and rejects single-cycle pulses.
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int          CNT_W       = 32
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sig_in,
  clk_freq_meter_if.slave   bus
);
  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [31:0] LAST = 32'(GATE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic             ovf, ovf_nxt;
  logic             rise, last, publish;
  logic [CNT_W-1:0] freq_count_q;
  logic             count_valid_q, overflow_q;

`ifdef CLK_FREQ_METER_DEGLITCH_EN
  logic s1, s2, s3;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else begin
      s1 <= sig_in; s2 <= s1; s3 <= s2;
    end
  end
  // new level must be seen on two consecutive samples before it counts
  assign rise = s1 & s2 & ~s3;
`else
  logic s1, s2, p;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; p <= 1'b0;
    end else begin
      s1 <= sig_in; s2 <= s1; p <= s2;
    end
  end
  assign rise = s2 & ~p;
`endif

  assign last = (gate_cnt == LAST);

  // edge count including this cycle's rise, saturating
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf;
    if (rise) begin
      if (&edge_cnt) ovf_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.abort && bus.start) state_d = GATE;
      end
      GATE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last) begin
          publish = 1'b1;
          state_d = bus.continuous ? GATE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      ovf           <= 1'b0;
      freq_count_q  <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= publish;
      if (publish) begin
        freq_count_q <= edge_nxt;
        overflow_q   <= ovf_nxt;
      end
      // counters sit at zero in IDLE and restart at every gate boundary
      if (state_q == IDLE || bus.abort || last) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 32'd1;
        edge_cnt <= edge_nxt;
        ovf      <= ovf_nxt;
      end
    end
  end

  assign bus.freq_count  = freq_count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q == GATE);
endmodule
